io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Round-robin arbiter and sequencer for a shared bidirectional parallel bus carried on the fabric's user IO pads. It sits inside `top`, between up to N_REQ internal requesters and a DATA_W-bit slice of `io_in`/`io_out`/`io_oeb`. It grants one requester at a time, latches its transfer direction, and drives or samples the pads beat by beat. It enforces a bounded tenure and a forced pad-release turnaround between owners, so two drivers never overlap on the pads.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, bus width in pads
- MAX_BURST, 16, maximum beats per tenure (1..255)
- TURN_CYCLES, 1, released-bus cycles between tenures (1..15)

Ports:
- clk  in  1  fabric global clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester bus request; held high for the whole tenure
- wr  in  N_REQ  per-requester direction (1 = drive pads, 0 = sample pads); sampled only at grant
- wdata  in  N_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W]
- gnt  out  N_REQ  one-hot grant, registered
- rdata  out  DATA_W  last sampled pad value
- rvalid  out  N_REQ  one-hot, one-cycle read-beat strobe to the owning requester
- busy  out  1  high in GRANT or TURN
- pad_in  in  DATA_W  from `io_in` slice
- pad_out  out  DATA_W  to `io_out` slice
- pad_oeb  out  DATA_W  to `io_oeb` slice; all bits equal; 1 = pad released/input

## Operation
- The FSM has three states: IDLE, GRANT and TURN.
- IDLE:
  - If any `req` is high, select the winner by round-robin, starting at ptr+1 and wrapping modulo N_REQ.
  - At the clock edge: set `gnt[w]`, set dir ← `wr[w]`, set beat ← 0, set ptr ← w, go to GRANT.
- GRANT, owner g: a beat is taken in each cycle where `req[g]`=1 and beat < MAX_BURST. At that edge:
  - Write (dir=1): `pad_out` ← `wdata[g]`, `pad_oeb` ← all 0.
  - Read (dir=0): `rdata` ← `pad_in`, `rvalid[g]` ← 1 for one cycle.
  - beat ← beat+1.
- GRANT release: when `req[g]`=0 or beat == MAX_BURST, no beat is taken. At that edge:
  - `gnt` ← 0, `pad_oeb` ← all 1, `pad_out` ← 0.
  - Load the turnaround counter with TURN_CYCLES and go to TURN.
- TURN: hold `gnt`=0 and `pad_oeb`=all 1, and decrement the counter. Go to IDLE on the edge where the counter reaches 1.
- Direction is fixed per tenure. A change on `wr[g]` during GRANT is ignored.
- Requests other than from g are ignored during GRANT and TURN. They are arbitrated in IDLE with round-robin fairness: the owner that just finished has the lowest priority.
- If the owner drops `req` and re-asserts it during TURN, it competes normally in IDLE.
- Reset (asynchronous, takes effect immediately, including mid-tenure):
  - state IDLE, `gnt`=0, `pad_oeb`=all 1, `pad_out`=0, `rdata`=0, `rvalid`=0, `busy`=0.
  - ptr=N_REQ-1, so requester 0 wins first.
- Width rules:
  - The beat counter is ceil(log2(MAX_BURST+1)) bits and never wraps.
  - ptr is ceil(log2(N_REQ)) bits, and the wrap is explicit modulo N_REQ, not a power-of-two overflow.

## Timing
- Request to grant: `req` sampled high in IDLE in cycle n gives `gnt` high in cycle n+1.
- Pad latency: the first beat is in cycle n+1. Write pads are driven from cycle n+2. The first `rvalid` is in cycle n+2 and carries `pad_in` as sampled at the n+1 edge.
- Beat throughput: one beat per cycle, back to back, with no bubbles while `req` is held.
- Release with k beats taken:
  - The release cycle is n+1+k. `gnt` is low from n+2+k.
  - Pads are released (`pad_oeb`=1) from n+2+k. The last written data is driven for exactly one cycle.
- Turnaround: TURN occupies TURN_CYCLES cycles, then IDLE takes one arbitration cycle.
  - Minimum gap from one `gnt` falling to the next `gnt` rising is TURN_CYCLES+1 cycles.
  - `pad_oeb` stays all 1 for at least TURN_CYCLES+1 cycles between owners.
- Zero-beat tenure: `req` dropped in the grant cycle gives a tenure with no beats and no pad drive. The arbiter still goes through TURN.
- `busy` is registered and aligned with the state.

## Test plan
- Reset behaviour: assert `rst_n`=0 mid-write with `pad_oeb`=0 → `pad_oeb`=8'hFF and `gnt`=0 in the same cycle (async). After release, `req`=4'b1111 → `gnt`=4'b0001.
- Single write of 3 beats: requester 2 with `wr`=1 and `wdata` values 0xA1, 0xA2, 0xA3:
  - `gnt`=4'b0100 at n+1.
  - `pad_out` is A1, A2, A3 at n+2..n+4, with `pad_oeb`=0x00.
  - `pad_oeb`=0xFF from n+5.
- Read with beat limit: MAX_BURST=16, requester 1 reads with `req` held for 20 cycles while `pad_in` counts up → exactly 16 `rvalid[1]` pulses with matching `rdata`, `gnt` drops after the 16th beat, then re-grant after TURN.
- Round-robin fairness: all four requesters hold `req` continuously, each releasing after 2 beats → grant order 0, 1, 2, 3, 0, with a gap of TURN_CYCLES+1 cycles and `pad_oeb`=0xFF between tenures.
- Direction latch and ignored requests: requester 0 granted with `wr`=0, then toggles `wr` to 1 mid-tenure → no pad drive and `pad_oeb` stays 0xFF. `req[3]` asserted mid-tenure is granted only after TURN.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin owner selection for a shared pad bus.
// Sequences read/write beats and forces a released turnaround between owners.
module io_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        wr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rvalid,
  output logic                    busy,
  input  logic [DATA_W-1:0]       pad_in,
  output logic [DATA_W-1:0]       pad_out,
  output logic [DATA_W-1:0]       pad_oeb
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int TURN_W = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                dir_q, dir_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [DATA_W-1:0]   pad_out_q, pad_out_d;
  logic                oeb_q, oeb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0]    rvalid_q, rvalid_d;
  logic                busy_q, busy_d;

  logic                win_vld;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W:0]      cand;
  logic [N_REQ-1:0]    win_oh;
  logic [N_REQ-1:0]    own_oh;
  logic                own_req;
  logic [DATA_W-1:0]   own_wdata;
  logic                beat_ok;

  // Round-robin search from ptr+1, wrapping explicitly modulo N_REQ
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!win_vld && req[cand[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Owner-side views: ptr holds the current (or last) owner
  always_comb begin
    win_oh    = N_REQ'(1) << win_idx;
    own_oh    = N_REQ'(1) << ptr_q;
    own_req   = req[ptr_q];
    own_wdata = wdata[ptr_q*DATA_W +: DATA_W];
    beat_ok   = own_req && (beat_q < BEAT_W'(MAX_BURST));
  end

  // Next-state, grant, beat and pad sequencing
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    dir_d     = dir_q;
    beat_d    = beat_q;
    ptr_d     = ptr_q;
    turn_d    = turn_q;
    pad_out_d = pad_out_q;
    oeb_d     = oeb_q;
    rdata_d   = rdata_q;
    rvalid_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_GRANT;
          gnt_d   = win_oh;
          dir_d   = wr[win_idx];
          beat_d  = '0;
          ptr_d   = win_idx;
        end
      end
      S_GRANT: begin
        if (beat_ok) begin
          beat_d = beat_q + BEAT_W'(1);
          if (dir_q) begin
            pad_out_d = own_wdata;
            oeb_d     = 1'b0;
          end else begin
            rdata_d  = pad_in;
            rvalid_d = own_oh;
          end
        end else begin
          state_d   = S_TURN;
          gnt_d     = '0;
          pad_out_d = '0;
          oeb_d     = 1'b1;
          turn_d    = TURN_W'(TURN_CYCLES);
        end
      end
      S_TURN: begin
        turn_d = turn_q - TURN_W'(1);
        if (turn_q <= TURN_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset releases the pads immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      dir_q     <= 1'b0;
      beat_q    <= '0;
      ptr_q     <= PTR_W'(N_REQ - 1);
      turn_q    <= '0;
      pad_out_q <= '0;
      oeb_q     <= 1'b1;
      rdata_q   <= '0;
      rvalid_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      dir_q     <= dir_d;
      beat_q    <= beat_d;
      ptr_q     <= ptr_d;
      turn_q    <= turn_d;
      pad_out_q <= pad_out_d;
      oeb_q     <= oeb_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = busy_q;
  assign pad_out = pad_out_q;
  assign pad_oeb = {DATA_W{oeb_q}};

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed checks of grant order, beats, limits
// and pad release for io_bus_arbiter (4 requesters, 8-bit bus).
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  wr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  rdata;
  logic [3:0]  rvalid;
  logic        busy;
  logic [7:0]  pad_in;
  logic [7:0]  pad_out;
  logic [7:0]  pad_oeb;

  int tests = 0;
  int fails = 0;
  int npulse;
  int ord [5];
  logic [3:0] exp_rv;
  logic [3:0] exp_g;

  always #5 clk = ~clk;

  io_bus_arbiter #(
    .N_REQ(4),
    .DATA_W(8),
    .MAX_BURST(16),
    .TURN_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .wr(wr),
    .wdata(wdata),
    .gnt(gnt),
    .rdata(rdata),
    .rvalid(rvalid),
    .busy(busy),
    .pad_in(pad_in),
    .pad_out(pad_out),
    .pad_oeb(pad_oeb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    wr     = '0;
    wdata  = '0;
    pad_in = '0;
    ord    = '{0, 1, 2, 3, 0};
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_oeb", pad_oeb, 8'hFF);
    chk("rst_pad_out", pad_out, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // single 3-beat write by requester 2
    req = 4'b0100;
    wr  = 4'b0100;
    wdata[23:16] = 8'hA1;
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_busy", busy, 1'b1);
    chk("t1_oeb_grant", pad_oeb, 8'hFF);
    @(negedge clk);
    chk("t1_out_a1", pad_out, 8'hA1);
    chk("t1_oeb_a1", pad_oeb, 8'h00);
    wdata[23:16] = 8'hA2;
    @(negedge clk);
    chk("t1_out_a2", pad_out, 8'hA2);
    wdata[23:16] = 8'hA3;
    @(negedge clk);
    chk("t1_out_a3", pad_out, 8'hA3);
    chk("t1_oeb_a3", pad_oeb, 8'h00);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_rel_oeb", pad_oeb, 8'hFF);
    chk("t1_rel_gnt", gnt, 4'b0000);
    chk("t1_rel_out", pad_out, 8'h00);
    chk("t1_turn_busy", busy, 1'b1);
    @(negedge clk);
    chk("t1_idle_busy", busy, 1'b0);

    // async reset mid-write, then zero-beat tenure
    req = 4'b0001;
    wr  = 4'b0001;
    wdata[7:0] = 8'h55;
    @(negedge clk);
    chk("t2_gnt", gnt, 4'b0001);
    @(negedge clk);
    chk("t2_out", pad_out, 8'h55);
    chk("t2_oeb_drive", pad_oeb, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("t2_async_oeb", pad_oeb, 8'hFF);
    chk("t2_async_gnt", gnt, 4'b0000);
    chk("t2_async_out", pad_out, 8'h00);
    chk("t2_async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    wr  = 4'b0000;
    @(negedge clk);
    chk("t2_first_win", gnt, 4'b0001);
    req = 4'b0000;
    @(negedge clk);
    chk("t2_zb_gnt", gnt, 4'b0000);
    chk("t2_zb_rvalid", rvalid, 4'b0000);
    chk("t2_zb_oeb", pad_oeb, 8'hFF);
    chk("t2_zb_busy", busy, 1'b1);
    @(negedge clk);
    chk("t2_zb_idle", busy, 1'b0);

    // read by requester 1 held 20 cycles, limited to 16 beats
    req    = 4'b0010;
    wr     = 4'b0000;
    npulse = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      exp_rv = (cyc >= 2 && cyc <= 17) ? 4'b0010 : 4'b0000;
      chk($sformatf("t3_rvalid_%0d", cyc), rvalid, exp_rv);
      if (rvalid[1]) begin
        npulse++;
        chk($sformatf("t3_rdata_%0d", cyc), rdata,
            8'(8'h40 + cyc - 2));
      end
      if (cyc == 1 || cyc == 17 || cyc == 20) begin
        chk($sformatf("t3_gnt_%0d", cyc), gnt, 4'b0010);
      end
      if (cyc == 18 || cyc == 19) begin
        chk($sformatf("t3_gnt_%0d", cyc), gnt, 4'b0000);
        chk($sformatf("t3_oeb_%0d", cyc), pad_oeb, 8'hFF);
      end
      pad_in = 8'(8'h40 + cyc - 1);
    end
    chk("t3_pulses", npulse, 16);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle", busy, 1'b0);

    // round robin with all requesters active, 2 beats each
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    wr    = 4'b1111;
    wdata = 32'hD3D2D1D0;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'(1 << ord[t]);
      @(negedge clk);
      chk($sformatf("t4_gnt_%0d", t), gnt, exp_g);
      @(negedge clk);
      chk($sformatf("t4_out1_%0d", t), pad_out,
          8'(8'hD0 + ord[t]));
      chk($sformatf("t4_oeb1_%0d", t), pad_oeb, 8'h00);
      @(negedge clk);
      chk($sformatf("t4_out2_%0d", t), pad_out,
          8'(8'hD0 + ord[t]));
      req[ord[t]] = 1'b0;
      @(negedge clk);
      chk($sformatf("t4_gap1_gnt_%0d", t), gnt, 4'b0000);
      chk($sformatf("t4_gap1_oeb_%0d", t), pad_oeb, 8'hFF);
      req[ord[t]] = 1'b1;
      @(negedge clk);
      chk($sformatf("t4_gap2_gnt_%0d", t), gnt, 4'b0000);
      chk($sformatf("t4_gap2_oeb_%0d", t), pad_oeb, 8'hFF);
    end
    req = 4'b0000;
    @(negedge clk);

    // direction latch and ignored foreign request
    req    = 4'b0001;
    wr     = 4'b0000;
    pad_in = 8'h3C;
    @(negedge clk);
    chk("t5_gnt0", gnt, 4'b0001);
    wr = 4'b0001;
    wdata[7:0] = 8'h77;
    @(negedge clk);
    chk("t5_oeb_a", pad_oeb, 8'hFF);
    chk("t5_rvalid", rvalid, 4'b0001);
    chk("t5_rdata", rdata, 8'h3C);
    req[3] = 1'b1;
    @(negedge clk);
    chk("t5_oeb_b", pad_oeb, 8'hFF);
    chk("t5_out", pad_out, 8'h00);
    chk("t5_hold_gnt", gnt, 4'b0001);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t5_turn_gnt", gnt, 4'b0000);
    @(negedge clk);
    chk("t5_idle_gnt", gnt, 4'b0000);
    @(negedge clk);
    chk("t5_gnt3", gnt, 4'b1000);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
